// File: rtl/store_align_buf_pkg.sv
// Shared constants for the MEM-stage store path: opcodes, lane count and the
// CP0 exception code raised for a rejected misaligned store.
package store_align_buf_pkg;

   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SB   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SW   = 2'b11;

   localparam int unsigned BE_W = 4;

   localparam logic [4:0] EXC_ADES = 5'd5;

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push/pop and an occupancy count.
// Full and empty are derived from the level; pointers wrap modulo DEPTH.
module store_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 68
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok, pop_ok;

   // Guard against overflow/underflow even if the caller misbehaves.
   assign push_ok = push_i && (level_q != LW'(DEPTH));
   assign pop_ok  = pop_i && (level_q != '0);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
      if (push_ok && !pop_ok) level_d = level_q + LW'(1);
      else if (pop_ok && !push_ok) level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/store_align_buf.sv
// Store alignment/formatting front end: checks alignment, builds byte enables and
// lane-replicated data, and queues the result toward data memory.
module store_align_buf
   import store_align_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [1:0]             st_op,
   input  logic [AW-1:0]          addr,
   input  logic [31:0]            wdata,
   output logic                   dm_valid,
   input  logic                   dm_ready,
   output logic [AW-1:0]          dm_addr,
   output logic [BE_W-1:0]        dm_be,
   output logic [31:0]            dm_wdata,
   output logic                   ades,
   output logic [AW-1:0]          ades_addr,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = AW + BE_W + 32;

   logic            aligned;
   logic [BE_W-1:0] be;
   logic [31:0]     fdata;
   logic            take, push, bad, pop;
   logic [EW-1:0]   entry, head;
   logic            ades_q, ades_d;
   logic [AW-1:0]   ades_addr_q, ades_addr_d;

   always_comb begin
      aligned = 1'b1;
      be      = '0;
      fdata   = '0;
      unique case (st_op)
         ST_SB: begin
            be    = 4'b0001 << addr[1:0];
            fdata = {4{wdata[7:0]}};
         end
         ST_SH: begin
            aligned = (addr[0] == 1'b0);
            be      = addr[1] ? 4'b1100 : 4'b0011;
            fdata   = {2{wdata[15:0]}};
         end
         ST_SW: begin
            aligned = (addr[1:0] == 2'b00);
            be      = 4'b1111;
            fdata   = wdata;
         end
         default: ;
      endcase
   end

   // st_op==ST_NONE is consumed without enqueue or exception.
   assign take  = in_valid && in_ready && (st_op != ST_NONE);
   assign push  = take && aligned;
   assign bad   = take && !aligned;
   assign entry = {addr[AW-1:2], 2'b00, be, fdata};

   assign in_ready = (level != LW'(DEPTH));
   assign dm_valid = (level != '0);
   assign pop      = dm_valid && dm_ready;

   store_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (entry),
      .rdata_o (head),
      .level_o (level)
   );

   assign dm_addr  = dm_valid ? head[EW-1 -: AW]       : '0;
   assign dm_be    = dm_valid ? head[32 +: BE_W]       : '0;
   assign dm_wdata = dm_valid ? head[31:0]             : '0;

   assign ades_d      = bad;
   assign ades_addr_d = bad ? addr : ades_addr_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ades_q      <= 1'b0;
         ades_addr_q <= '0;
      end else begin
         ades_q      <= ades_d;
         ades_addr_q <= ades_addr_d;
      end
   end

   assign ades      = ades_q;
   assign ades_addr = ades_addr_q;

endmodule

// File: tb/tb_store_align_buf.sv
// Directed plus randomized checks of store_align_buf against a queue-based model.
module tb_store_align_buf;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned AW    = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  st_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        dm_valid;
   logic        dm_ready;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wdata;
   logic        ades;
   logic [31:0] ades_addr;
   logic [1:0]  level;

   always #5 clk = ~clk;

   store_align_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .st_op     (st_op),
      .addr      (addr),
      .wdata     (wdata),
      .dm_valid  (dm_valid),
      .dm_ready  (dm_ready),
      .dm_addr   (dm_addr),
      .dm_be     (dm_be),
      .dm_wdata  (dm_wdata),
      .ades      (ades),
      .ades_addr (ades_addr),
      .level     (level)
   );

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_ades;
   logic [31:0] m_ades_addr;
   int          passed = 0;
   int          total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: one clock edge computed from the rules, using byte arithmetic.
   task automatic model_edge(input logic rst_n, input logic iv, input logic [1:0] op,
                             input logic [31:0] ad, input logic [31:0] wd, input logic rd);
      int unsigned size, lane;
      logic        room, pop_now, take, ok;
      ent_t        e;
      if (!rst_n) begin
         q.delete();
         m_ades      = 1'b0;
         m_ades_addr = '0;
         return;
      end
      room    = (q.size() != DEPTH);
      pop_now = (q.size() != 0) && rd;
      take    = iv && room && (op != 2'b00);
      size    = 1 << (op - 1);
      ok      = (ad % size) == 0;
      lane    = ad % 4;
      if (pop_now) void'(q.pop_front());
      if (take && ok) begin
         e.a  = ad - lane;
         e.be = 4'(((1 << size) - 1) << (lane - (lane % size)));
         if (size == 1)      e.d = 32'(wd % 256) * 32'h0101_0101;
         else if (size == 2) e.d = 32'(wd % 65536) * 32'h0001_0001;
         else                e.d = wd;
         q.push_back(e);
      end
      m_ades = take && !ok;
      if (m_ades) m_ades_addr = ad;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"},     64'(level),     64'(q.size()));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
      chk({tag, ".dm_valid"},  64'(dm_valid),  64'(q.size() != 0));
      chk({tag, ".dm_addr"},   64'(dm_addr),   q.size() != 0 ? 64'(q[0].a)  : 64'd0);
      chk({tag, ".dm_be"},     64'(dm_be),     q.size() != 0 ? 64'(q[0].be) : 64'd0);
      chk({tag, ".dm_wdata"},  64'(dm_wdata),  q.size() != 0 ? 64'(q[0].d)  : 64'd0);
      chk({tag, ".ades"},      64'(ades),      64'(m_ades));
      chk({tag, ".ades_addr"}, 64'(ades_addr), 64'(m_ades_addr));
   endtask

   task automatic cyc(input string tag, input logic rst_n, input logic iv, input logic [1:0] op,
                      input logic [31:0] ad, input logic [31:0] wd, input logic rd);
      reset    = rst_n;
      in_valid = iv;
      st_op    = op;
      addr     = ad;
      wdata    = wd;
      dm_ready = rd;
      @(posedge clk);
      model_edge(rst_n, iv, op, ad, wd, rd);
      #1;
      check_all(tag);
   endtask

   initial begin
      m_ades      = 1'b0;
      m_ades_addr = '0;
      cyc("rst", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      cyc("rst2", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_dm_valid", 64'(dm_valid), 64'd0);

      // sb to lane 3
      cyc("sb", 1'b1, 1'b1, 2'b01, 32'h0000_1003, 32'h1234_56AB, 1'b1);
      chk("sb_addr", 64'(dm_addr), 64'h1000);
      chk("sb_be", 64'(dm_be), 64'b1000);
      chk("sb_data", 64'(dm_wdata), 64'hABAB_ABAB);
      cyc("sb_pop", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk("sb_level0", 64'(level), 64'd0);

      // sh upper half, then misaligned sh
      cyc("sh", 1'b1, 1'b1, 2'b10, 32'h0000_2002, 32'hDEAD_BEEF, 1'b0);
      chk("sh_be", 64'(dm_be), 64'b1100);
      chk("sh_data", 64'(dm_wdata), 64'hBEEF_BEEF);
      cyc("sh_bad", 1'b1, 1'b1, 2'b10, 32'h0000_2001, 32'h1111_2222, 1'b0);
      chk("ades_pulse", 64'(ades), 64'd1);
      chk("ades_addr", 64'(ades_addr), 64'h2001);
      chk("sh_bad_level", 64'(level), 64'd1);
      cyc("ades_end", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk("ades_low", 64'(ades), 64'd0);

      // fill with sw, third waits; then drain with push+pop at full
      cyc("sw1", 1'b1, 1'b1, 2'b11, 32'h0000_4000, 32'hA000_0001, 1'b0);
      cyc("sw2", 1'b1, 1'b1, 2'b11, 32'h0000_4004, 32'hA000_0002, 1'b0);
      cyc("sw3", 1'b1, 1'b1, 2'b11, 32'h0000_4008, 32'hA000_0003, 1'b0);
      chk("full_level", 64'(level), 64'd2);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_head", 64'(dm_wdata), 64'hA000_0001);
      cyc("sw3_full_pop", 1'b1, 1'b1, 2'b11, 32'h0000_4008, 32'hA000_0003, 1'b1);
      chk("after_full_pop", 64'(level), 64'd1);
      cyc("sw3_acc", 1'b1, 1'b1, 2'b11, 32'h0000_4008, 32'hA000_0003, 1'b1);
      chk("pushpop_level", 64'(level), 64'd1);
      chk("order_third", 64'(dm_wdata), 64'hA000_0003);
      cyc("drain", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

      // reset mid-transfer
      cyc("q1", 1'b1, 1'b1, 2'b11, 32'h0000_5000, 32'h5555_0001, 1'b0);
      cyc("q2", 1'b1, 1'b1, 2'b01, 32'h0000_5001, 32'h5555_0002, 1'b0);
      cyc("midrst", 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
      chk("midrst_valid", 64'(dm_valid), 64'd0);
      cyc("post_rst", 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

      // st_op none is silently consumed
      cyc("none", 1'b1, 1'b1, 2'b00, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
      chk("none_level", 64'(level), 64'd0);
      chk("none_ades", 64'(ades), 64'd0);

      for (int i = 0; i < 500; i++) begin
         cyc("rand",
             ($urandom_range(63) != 0),
             ($urandom_range(3) != 0),
             2'($urandom_range(3)),
             $urandom,
             $urandom,
             1'($urandom_range(1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/store_align_buf.md
Name: store_align_buf

Overview:
- MEM-stage store path: the narrowing counterpart of the 16→32 immediate/load extender.
- Takes a 32-bit register value plus a store opcode (sb/sh/sw) and produces word-aligned address, byte-enables and lane-replicated write data.
- Results are queued in a small FIFO that decouples the pipeline from a data memory with a valid/ready handshake.
- Misaligned halfword/word stores are rejected and reported as an address-error-on-store (AdES) pulse.

Parameters:
- DEPTH, 2, FIFO entries (power of two, ≥2).
- AW, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at posedge clears state).
- in_valid  in  1  store request from MEM stage.
- in_ready  out  1  buffer can accept a request this cycle.
- st_op  in  2  00 none, 01 sb, 10 sh, 11 sw.
- addr  in  AW  byte address from ALU.
- wdata  in  32  rt register value.
- dm_valid  out  1  head entry presented to data memory.
- dm_ready  in  1  data memory accepts head.
- dm_addr  out  AW  {addr[AW-1:2],2'b00} of head entry.
- dm_be  out  4  byte enables of head entry, bit i = byte lane i (little-endian).
- dm_wdata  out  32  lane-replicated data of head entry.
- ades  out  1  one-cycle pulse: misaligned store rejected.
- ades_addr  out  AW  offending byte address, held until next ades.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset (reset==0 at posedge):
- FIFO empty, pointers 0, level=0, dm_valid=0, ades=0, ades_addr=0.
- dm_addr/dm_be/dm_wdata read 0 while empty.
- Reset mid-transfer drops all queued entries; no partial write is replayed.

Handshakes:
- in_ready = (level != DEPTH), purely from registered state, with no combinational path from dm_ready.
- Accept = in_valid & in_ready & st_op!=00 & aligned.
- st_op==00 with in_valid is consumed silently: no enqueue, no ades.
- Pop = dm_valid & dm_ready; dm_valid = (level != 0).
- Payload is stable while dm_valid & !dm_ready.

Alignment (combinational on input):
- sb: always aligned.
- sh: addr[0]==0.
- sw: addr[1:0]==00.
- Misaligned with in_valid & in_ready: not enqueued; next cycle ades=1 and ades_addr=addr.
- Misaligned while full (in_ready=0): no ades; the request waits.

Formatting (lane index a=addr[1:0]):
- sb: be=4'b0001<<a, wdata={4{wdata[7:0]}}.
- sh: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}}.
- sw: be=4'b1111, wdata unchanged.

Latency:
- Request accepted at edge N appears at the head (dm_valid=1) after edge N if the FIFO was empty. No bypass.

Occupancy:
- Push and pop in the same cycle leave level unchanged and advance both pointers.
- When full, a simultaneous pop does not open in_ready in that same cycle.
- Pointers wrap modulo DEPTH; full/empty are derived from level.

Ordering: strict FIFO; entries are never merged or reordered.

Decomposition:
- Shared package holds:
  - ST_NONE/ST_SB/ST_SH/ST_SW opcode constants;
  - the BE width constant;
  - the ades exception-code constant (ExcCode 5) used by CP0.
- One natural sub-module: store_fifo. It is a generic DEPTH×(AW+4+32) synchronous FIFO with push/pop/level and the same active-low synchronous reset.
- Formatting and alignment checks live in the top module.

Test Plan:
- sb addr=0x0000_1003, wdata=0x1234_56AB, dm_ready=1 → next cycle dm_valid=1, dm_addr=0x0000_1000, dm_be=1000, dm_wdata=0xABAB_ABAB; level returns to 0 after pop.
- sh addr=0x2002, wdata=0xDEAD_BEEF → dm_be=1100, dm_wdata=0xBEEF_BEEF. Then sh addr=0x2001 → no enqueue, ades=1 for exactly one cycle, ades_addr=0x2001.
- dm_ready=0, three sw pushes (DEPTH=2) → first two accepted, level=2, in_ready=0, third held. Raise dm_ready → entries emerge in order, then the third is accepted.
- Full FIFO with push+pop asserted together → level stays 2 that cycle, in_ready remains 0 until the following cycle.
- Two entries queued, then reset=0 for one edge → dm_valid=0, level=0, ades=0; no further dm traffic after release.
- st_op=00 with in_valid=1, addr=0x3 → no enqueue, no ades, level unchanged.
